// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master command port among NUM_REQ requesters.
// Optional watchdog on the wait states is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int CMD_WIDTH      = 12,
   parameter int READ_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_vld,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
   output logic [NUM_REQ-1:0]             req_rdy,
   output logic [NUM_REQ-1:0]             rsp_vld,
   output logic [READ_WIDTH-1:0]          rsp_data,
   output logic                           rsp_err,
   output logic [CMD_WIDTH-1:0]           spi_cmd,
   output logic                           spi_cmd_vld,
   input  logic                           spi_cmd_rdy,
   input  logic                           spi_read_vld,
   input  logic [READ_WIDTH-1:0]          spi_read_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       gnt_q, gnt_d;
   logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
   logic                   cmd_vld_q, cmd_vld_d;
   logic [NUM_REQ-1:0]     req_rdy_q, req_rdy_d;
   logic [NUM_REQ-1:0]     rsp_vld_q, rsp_vld_d;
   logic [READ_WIDTH-1:0]  rsp_q, rsp_d;
   logic                   busy_seen_q, busy_seen_d;
   logic                   found;
   logic [IDX_W-1:0]       pick;
   logic                   tmo_hit;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic             rsp_err_q, rsp_err_d;

   // Counter is zero on the first wait cycle; it fires so that the response lands TIMEOUT_CYCLES after entry.
   assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = '0;
      if (state_q == WAIT_WR || state_q == WAIT_RD) tmo_d = tmo_q + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // First requester at or above ptr, wrapping around.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] idx_c;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_c = IDX_W'(idx);
         if (!found && req_vld[idx_c]) begin
            found = 1'b1;
            pick  = idx_c;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      cmd_d       = cmd_q;
      cmd_vld_d   = cmd_vld_q;
      req_rdy_d   = '0;
      rsp_vld_d   = '0;
      rsp_d       = rsp_q;
      busy_seen_d = busy_seen_q;
`ifdef SPI_ARB_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d           = pick;
               cmd_d           = req_cmd[pick*CMD_WIDTH +: CMD_WIDTH];
               cmd_vld_d       = 1'b1;
               req_rdy_d[pick] = 1'b1;
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_vld_q && spi_cmd_rdy) begin
               cmd_vld_d   = 1'b0;
               busy_seen_d = 1'b0;
               state_d     = cmd_q[CMD_WIDTH-1] ? WAIT_WR : WAIT_RD;
            end
         end
         WAIT_WR: begin
            // Write is done once the master has gone busy and returned to idle.
            if (busy_seen_q && spi_cmd_rdy) begin
               rsp_d            = '0;
               rsp_vld_d[gnt_q] = 1'b1;
               state_d          = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
               rsp_err_d        = 1'b0;
`endif
            end else if (tmo_hit) begin
               rsp_d            = '1;
               rsp_vld_d[gnt_q] = 1'b1;
               state_d          = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
               rsp_err_d        = 1'b1;
`endif
            end else if (!spi_cmd_rdy) begin
               busy_seen_d = 1'b1;
            end
         end
         WAIT_RD: begin
            if (spi_read_vld) begin
               rsp_d            = spi_read_data;
               rsp_vld_d[gnt_q] = 1'b1;
               state_d          = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
               rsp_err_d        = 1'b0;
`endif
            end else if (tmo_hit) begin
               rsp_d            = '1;
               rsp_vld_d[gnt_q] = 1'b1;
               state_d          = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
               rsp_err_d        = 1'b1;
`endif
            end
         end
         RESP: begin
            ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         cmd_q       <= '0;
         cmd_vld_q   <= 1'b0;
         req_rdy_q   <= '0;
         rsp_vld_q   <= '0;
         rsp_q       <= '0;
         busy_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         cmd_q       <= cmd_d;
         cmd_vld_q   <= cmd_vld_d;
         req_rdy_q   <= req_rdy_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_q       <= rsp_d;
         busy_seen_q <= busy_seen_d;
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         rsp_err_q <= rsp_err_d;
      end
   end
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_rdy     = req_rdy_q;
   assign rsp_vld     = rsp_vld_q;
   assign rsp_data    = rsp_q;
   assign spi_cmd     = cmd_q;
   assign spi_cmd_vld = cmd_vld_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: directed transactions, expected grants/responses queued
// by the stimulus and checked by an independent monitor.
module tb_spi_req_arbiter;
   localparam int NR = 4;
   localparam int CW = 12;
   localparam int RW = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [NR-1:0]       req_vld;
   logic [NR*CW-1:0]    req_cmd;
   logic [NR-1:0]       req_rdy;
   logic [NR-1:0]       rsp_vld;
   logic [RW-1:0]       rsp_data;
   logic                rsp_err;
   logic [CW-1:0]       spi_cmd;
   logic                spi_cmd_vld;
   logic                spi_cmd_rdy;
   logic                spi_read_vld;
   logic [RW-1:0]       spi_read_data;

   typedef struct packed {logic [NR-1:0] rdy; logic [CW-1:0] cmd;} gexp_t;
   typedef struct packed {logic [NR-1:0] vld; logic [RW-1:0] data; logic err;} rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t mg;
   rexp_t mr;
   int    checks = 0;
   int    failures = 0;
   int    hs_count = 0;

   spi_req_arbiter #(.NUM_REQ(NR), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_cmd(req_cmd), .req_rdy(req_rdy),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .spi_cmd(spi_cmd),
      .spi_cmd_vld(spi_cmd_vld), .spi_cmd_rdy(spi_cmd_rdy), .spi_read_vld(spi_read_vld),
      .spi_read_data(spi_read_data));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic gexp_t mkg(input logic [NR-1:0] r, input logic [CW-1:0] c);
      gexp_t g;
      g.rdy = r;
      g.cmd = c;
      return g;
   endfunction

   function automatic rexp_t mkr(input logic [NR-1:0] v, input logic [RW-1:0] d, input logic e);
      rexp_t r;
      r.vld  = v;
      r.data = d;
      r.err  = e;
      return r;
   endfunction

   // Monitor: compares every grant and response the DUT presents against the queues.
   always @(negedge clk) begin
      if (spi_cmd_vld && spi_cmd_rdy) hs_count++;
      if (req_rdy != '0) begin
         if (gq.size() == 0) check("grant_unexpected", 32'(req_rdy), 32'd0);
         else begin
            mg = gq.pop_front();
            check("grant_rdy", 32'(req_rdy), 32'(mg.rdy));
            check("grant_cmd", 32'(spi_cmd), 32'(mg.cmd));
            check("grant_cmd_vld", 32'(spi_cmd_vld), 32'd1);
         end
      end
      if (rsp_vld != '0) begin
         if (rq.size() == 0) check("rsp_unexpected", 32'(rsp_vld), 32'd0);
         else begin
            mr = rq.pop_front();
            check("rsp_vld", 32'(rsp_vld), 32'(mr.vld));
            check("rsp_data", 32'(rsp_data), 32'(mr.data));
            check("rsp_err", 32'(rsp_err), 32'(mr.err));
         end
      end
   end

   task automatic wait_hs(input int idx, input bit drop);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (drop && req_rdy[idx]) req_vld[idx] = 1'b0;
         if (spi_cmd_vld && spi_cmd_rdy) got = 1'b1;
      end
      check("hs_wait", 32'(got), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic spi_read(input int d, input logic [RW-1:0] v);
      repeat (d - 1) @(posedge clk);
      #1;
      spi_read_vld  = 1'b1;
      spi_read_data = v;
      @(posedge clk);
      #1;
      spi_read_vld  = 1'b0;
   endtask

   task automatic wait_rsp();
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rsp_vld != '0) got = 1'b1;
      end
      check("rsp_wait", 32'(got), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic stray_read();
      spi_read_vld  = 1'b1;
      spi_read_data = 8'hEE;
      @(posedge clk);
      #1;
      spi_read_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
      check({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_spi_cmd"}, 32'(spi_cmd), 32'd0);
      check({tag, "_spi_cmd_vld"}, 32'(spi_cmd_vld), 32'd0);
   endtask

   initial begin
      int bad;
      int hs0;
      int n;
      bit got;
      rst = 1'b1; req_vld = '0; req_cmd = '0;
      spi_cmd_rdy = 1'b1; spi_read_vld = 1'b0; spi_read_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single read from requester 2
      gq.push_back(mkg(4'b0100, 12'h0A5));
      rq.push_back(mkr(4'b0100, 8'h3C, 1'b0));
      req_cmd[2*CW +: CW] = 12'h0A5;
      req_vld[2] = 1'b1;
      wait_hs(2, 1'b1);
      spi_read(2, 8'h3C);
      wait_rsp();
      stray_read();

      // Write from requester 0 with 20 busy cycles
      gq.push_back(mkg(4'b0001, 12'h812));
      rq.push_back(mkr(4'b0001, 8'h00, 1'b0));
      req_cmd[0 +: CW] = 12'h812;
      req_vld[0] = 1'b1;
      wait_hs(0, 1'b1);
      spi_cmd_rdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      spi_cmd_rdy = 1'b1;
      @(negedge clk);
      check("wr_not_early", 32'(rsp_vld), 32'd0);
      @(negedge clk);
      check("wr_rsp_latency", 32'(rsp_vld), 32'b0001);
      @(posedge clk);
      #1;

      // Back-pressure in ISSUE, requester 1
      spi_cmd_rdy = 1'b0;
      gq.push_back(mkg(4'b0010, 12'h1F0));
      rq.push_back(mkr(4'b0010, 8'h77, 1'b0));
      hs0 = hs_count;
      req_cmd[1*CW +: CW] = 12'h1F0;
      req_vld[1] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (spi_cmd_vld) got = 1'b1;
      end
      check("bp_issue_seen", 32'(got), 32'd1);
      req_vld[1] = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         spi_read_vld = (i == 0);
         @(negedge clk);
         if (spi_cmd_vld !== 1'b1 || spi_cmd !== 12'h1F0) bad++;
      end
      check("bp_stable", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      spi_read_vld = 1'b0;
      spi_cmd_rdy  = 1'b1;
      wait_hs(1, 1'b0);
      spi_read(3, 8'h77);
      wait_rsp();
      check("bp_handshakes", 32'(hs_count - hs0), 32'd1);

      // Reset during WAIT_RD, requester 3
      gq.push_back(mkg(4'b1000, 12'h0F3));
      req_cmd[3*CW +: CW] = 12'h0F3;
      req_vld[3] = 1'b1;
      wait_hs(3, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_mid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      stray_read();

      // Fairness: all four held high for eight transactions
      for (int k = 0; k < 8; k++) begin
         gq.push_back(mkg(NR'(1) << (k % 4), 12'h010 + 12'(k % 4)));
         rq.push_back(mkr(NR'(1) << (k % 4), 8'h50 + 8'(k), 1'b0));
      end
      for (int i = 0; i < NR; i++) req_cmd[i*CW +: CW] = 12'h010 + 12'(i);
      req_vld = 4'hF;
      for (int k = 0; k < 8; k++) begin
         wait_hs(0, 1'b0);
         if (k == 7) req_vld = '0;
         spi_read(1, 8'h50 + 8'(k));
         wait_rsp();
      end

      // Asynchronous reset in the first ISSUE cycle drops spi_cmd_vld at once
      spi_cmd_rdy = 1'b0;
      req_cmd[0 +: CW] = 12'h8AA;
      req_vld[0] = 1'b1;
      @(posedge clk);
      #1;
      check("iss_vld_pre", 32'(spi_cmd_vld), 32'd1);
      rst = 1'b1;
      req_vld = '0;
      #1;
      check("iss_rst_vld", 32'(spi_cmd_vld), 32'd0);
      check("iss_rst_rdy", 32'(req_rdy), 32'd0);
      check("iss_rst_cmd", 32'(spi_cmd), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      spi_cmd_rdy = 1'b1;
      @(posedge clk);
      #1;

`ifdef SPI_ARB_TIMEOUT_EN
      // Read with no strobe times out 16 cycles after entering WAIT_RD
      gq.push_back(mkg(4'b0010, 12'h0C3));
      rq.push_back(mkr(4'b0010, 8'hFF, 1'b1));
      req_cmd[1*CW +: CW] = 12'h0C3;
      req_vld[1] = 1'b1;
      wait_hs(1, 1'b1);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         n++;
         if (rsp_vld != '0) got = 1'b1;
      end
      check("tmo_latency", 32'(n), 32'd17);
      @(posedge clk);
      #1;
`else
      n = 0;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("grant_queue_drained", 32'(gq.size()), 32'd0 + 32'(n - n));
      check("rsp_queue_drained", 32'(rq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter that shares one SPI master command port between `NUM_REQ` requesters. It accepts a command from one requester at a time and issues it to the SPI master with a valid/ready handshake. It waits for the transfer to complete, then routes read data, or a write acknowledge, back to the granted requester. It sits between the register-access clients and the SPI master.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CMD_WIDTH`, 12: command width; bit `CMD_WIDTH-1` = 1 for write, 0 for read.
- `READ_WIDTH`, 8: read data width.
- `TIMEOUT_CYCLES`, 1023: watchdog limit; used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_vld` in `NUM_REQ`: per-requester command valid.
- `req_cmd` in `NUM_REQ*CMD_WIDTH`: packed commands; requester i occupies `[i*CMD_WIDTH +: CMD_WIDTH]`.
- `req_rdy` out `NUM_REQ`: one-hot, one-cycle pulse marking the accepted command.
- `rsp_vld` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `rsp_data` out `READ_WIDTH`: read data; 0 for writes; valid while `rsp_vld` is nonzero.
- `rsp_err` out 1: timeout flag, valid with `rsp_vld`.
- `spi_cmd` out `CMD_WIDTH`: command to the SPI master.
- `spi_cmd_vld` out 1: command valid to the SPI master.
- `spi_cmd_rdy` in 1: SPI master ready (idle).
- `spi_read_vld` in 1: SPI master read-data strobe.
- `spi_read_data` in `READ_WIDTH`: SPI master read data.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT_WR`, `WAIT_RD`, `RESP`.
- **IDLE:** if any `req_vld` is set, grant the first set bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
  - Latch the granted command into `cmd_q` and the grant index into `gnt`.
  - Pulse `req_rdy[gnt]` for one cycle; go to `ISSUE`.
- **ISSUE:** `spi_cmd_vld`=1 and `spi_cmd`=`cmd_q`, both held stable until `spi_cmd_vld & spi_cmd_rdy`.
  - On the handshake go to `WAIT_WR` if `cmd_q[CMD_WIDTH-1]`=1, otherwise `WAIT_RD`.
  - Clear `busy_seen` on the handshake.
- **WAIT_WR:** set `busy_seen` when `spi_cmd_rdy`=0. Complete on the first cycle with `busy_seen`=1 and `spi_cmd_rdy`=1; set `rsp_q`=0 and go to `RESP`.
- **WAIT_RD:** on `spi_read_vld`=1, capture `spi_read_data` into `rsp_q` and go to `RESP`.
- **RESP:** pulse `rsp_vld[gnt]` for one cycle with `rsp_data`=`rsp_q`; set `ptr` to `(gnt+1) mod NUM_REQ`; go to `IDLE`.
- The arbiter allows only one outstanding command.
- `spi_read_vld` is ignored outside `WAIT_RD`.
- `req_vld` deasserting after `req_rdy` has no effect on the transaction in flight.

## Timing
- Reset values:
  - Outputs: `req_rdy`=0, `rsp_vld`=0, `rsp_data`=0, `rsp_err`=0, `spi_cmd`=0, `spi_cmd_vld`=0.
  - Internal: state=`IDLE`, `ptr`=0, `gnt`=0.
- All outputs are registered.
- `req_vld` sampled in `IDLE` → `req_rdy` high the next cycle; `spi_cmd_vld` rises in the same cycle as `req_rdy`.
- The SPI completion event (read strobe, or `spi_cmd_rdy` returning high after busy) → `rsp_vld` the next cycle.
- The earliest next grant is sampled the cycle after `rsp_vld`. Minimum turnaround is 2 idle cycles between transactions.
- Simultaneous requests: the fair pointer guarantees that each active requester waits at most `NUM_REQ-1` transactions.
- `ptr` wraps from `NUM_REQ-1` to 0.
- Reset asserted mid-transaction drops `spi_cmd_vld` immediately (asynchronously). The transaction is abandoned and no response is issued.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to `WAIT_WR` or `WAIT_RD` and increments each cycle in those states.
  - When it reaches `TIMEOUT_CYCLES`, go to `RESP` with `rsp_data` all-ones and `rsp_err`=1.
- `SPI_ARB_TIMEOUT_EN` undefined: there is no counter, `rsp_err` is tied to 0, and the wait states wait indefinitely.

## Test plan
- Single read, requester 2: cmd=0x0A5, `spi_read_data`=0x3C two cycles after the handshake → `req_rdy`=4'b0100, `spi_cmd`=0x0A5, `rsp_vld`=4'b0100 with `rsp_data`=0x3C.
- Write, requester 0: cmd=0x812; the SPI model drops `spi_cmd_rdy` for 20 cycles → `rsp_vld`=4'b0001 one cycle after `spi_cmd_rdy` rises, with `rsp_data`=0.
- Fairness: all four `req_vld` held high for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Back-pressure: `spi_cmd_rdy`=0 for 5 cycles in `ISSUE` → `spi_cmd_vld` and `spi_cmd` stay constant; exactly one handshake occurs.
- Reset mid-read: `rst` pulsed during `WAIT_RD` → all outputs 0, no `rsp_vld`, and the next grant starts searching at requester 0.
- With `SPI_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, read with no `spi_read_vld` → `rsp_vld` with `rsp_data`=0xFF, `rsp_err`=1, 16 cycles after entering `WAIT_RD`.
